// File: rtl/order_tx_framer_if.sv
// Order-path bundle: upstream order capture/status plus the outbound valid/ready byte link.
// master = framer side, slave = upstream processor and link partner.
interface order_tx_framer_if #(
  parameter int CLIENT_W = 5
);
  logic                send_order;
  logic [CLIENT_W-1:0] order_client_id;
  logic [31:0]         order_amount;
  logic                fifo_full;
  logic                order_dropped;
  logic [7:0]          drop_count;
  logic                busy;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_last;
  logic                tx_ready;

  modport master (
    input  send_order, order_client_id, order_amount, tx_ready,
    output fifo_full, order_dropped, drop_count, busy, tx_data, tx_valid, tx_last
  );

  modport slave (
    output send_order, order_client_id, order_amount, tx_ready,
    input  fifo_full, order_dropped, drop_count, busy, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/order_tx_framer.sv
// Buffers approved orders in a DEPTH-entry FIFO and sends each as a 7-byte frame (SOF, id, amt x4, XOR chk).
// SOF is valid 2 edges after send_order; tx_ready low stalls the byte in place; a full FIFO drops new orders.
module order_tx_framer #(
  parameter int         DEPTH    = 4,
  parameter int         CLIENT_W = 5,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  order_tx_framer_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_AMT, S_CHK} state_t;
  typedef struct packed {
    logic [CLIENT_W-1:0] id;
    logic [31:0]         amt;
  } ord_t;

  ord_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  state_t        state, state_nxt;
  logic [1:0]    amt_idx, amt_idx_nxt;
  ord_t          frm;
  logic [7:0]    chk;
  logic [7:0]    drop_cnt;
  logic          dropped;
  logic          push, pop, xfer, tx_vld, fifo_empty, full;
  logic [7:0]    byte_out;

  assign fifo_empty = (count == '0);
  assign full       = (count == CW'(DEPTH));
  // Space is judged on the pre-edge count, so a same-edge pop never admits a push.
  assign push       = bus.send_order && !full;
  assign tx_vld     = (state != S_IDLE);
  assign xfer       = tx_vld && bus.tx_ready;

  always_comb begin
    byte_out = 8'h00;
    case (state)
      S_SOF:   byte_out = SOF_BYTE;
      S_ID:    byte_out = 8'(frm.id);
      S_AMT:   byte_out = 8'(frm.amt >> {~amt_idx, 3'b000});
      S_CHK:   byte_out = chk;
      default: byte_out = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    amt_idx_nxt = amt_idx;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_SOF;
        end
      end
      S_SOF: if (xfer) state_nxt = S_ID;
      S_ID: begin
        if (xfer) begin
          state_nxt   = S_AMT;
          amt_idx_nxt = 2'd0;
        end
      end
      S_AMT: begin
        if (xfer) begin
          if (amt_idx == 2'd3) state_nxt = S_CHK;
          else amt_idx_nxt = amt_idx + 2'd1;
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_SOF;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      amt_idx <= 2'd0;
    end else begin
      state   <= state_nxt;
      amt_idx <= amt_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: bus.order_client_id, amt: bus.order_amount};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame register decouples the in-flight frame from the FIFO, so the slot frees at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm <= '0;
      chk <= 8'h00;
    end else if (pop) begin
      frm <= mem[rd_ptr];
      chk <= 8'h00;
    end else if (xfer && (state == S_ID || state == S_AMT)) begin
      chk <= chk ^ byte_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped  <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      dropped <= bus.send_order && full;
      if (bus.send_order && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end

  assign bus.tx_data       = byte_out;
  assign bus.tx_valid      = tx_vld;
  assign bus.tx_last       = (state == S_CHK);
  assign bus.fifo_full     = full;
  assign bus.busy          = tx_vld || !fifo_empty;
  assign bus.order_dropped = dropped;
  assign bus.drop_count    = drop_cnt;
endmodule

// File: tb/tb_order_tx_framer.sv
// Bench for order_tx_framer: frame vector table, hand-written corner sequences, and a random run
// compared every cycle against a queue-based model of the order path.
module tb_order_tx_framer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  order_tx_framer_if #(.CLIENT_W(5)) bus ();
  order_tx_framer #(.DEPTH(DEPTH), .CLIENT_W(5), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_pulses = 0;

  typedef struct { logic [4:0] id; logic [31:0] amt; } ord_t;
  typedef struct { logic [4:0] id; logic [31:0] amt; logic [55:0] exp; } vec_t;
  typedef struct { logic [7:0] d; logic l; int c; } cap_t;

  vec_t vt [6];
  cap_t cap [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [55:0] make_frame(logic [4:0] id, logic [31:0] amt);
    logic [7:0] idb;
    logic [7:0] c;
    idb = {3'b000, id};
    c   = idb ^ amt[31:24] ^ amt[23:16] ^ amt[15:8] ^ amt[7:0];
    return {8'hA5, idb, amt, c};
  endfunction

  function automatic logic [7:0] byte_of(logic [55:0] f, int i);
    logic [55:0] s;
    s = f >> (8 * (6 - i));
    return s[7:0];
  endfunction

  // Reference model: an order queue plus the frame being sent as a byte array and position.
  ord_t        mq [$];
  ord_t        m_in;
  logic [55:0] m_frame;
  int          m_idx, m_dc, m_pre;
  bit          m_active, m_dropped, m_xfer, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 0; m_idx = 0; m_dropped = 0; m_dc = 0; m_frame = '0;
    end else begin
      m_pre     = mq.size();
      m_xfer    = m_active && bus.tx_ready;
      m_push    = bus.send_order && (m_pre < DEPTH);
      m_dropped = bus.send_order && !m_push;
      if (m_dropped && m_dc < 255) m_dc++;
      if (!m_active || (m_xfer && m_idx == 6)) begin
        if (m_pre > 0) begin
          m_in     = mq.pop_front();
          m_frame  = make_frame(m_in.id, m_in.amt);
          m_idx    = 0;
          m_active = 1;
        end else begin
          m_active = 0;
        end
      end else if (m_xfer) begin
        m_idx++;
      end
      if (m_push) begin
        m_in.id  = bus.order_client_id;
        m_in.amt = bus.order_amount;
        mq.push_back(m_in);
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    check("tx_valid", 32'(bus.tx_valid), 32'(m_active));
    if (m_active) begin
      check("tx_data", 32'(bus.tx_data), 32'(byte_of(m_frame, m_idx)));
      check("tx_last", 32'(bus.tx_last), 32'(m_idx == 6));
    end
    check("fifo_full", 32'(bus.fifo_full), 32'(mq.size() == DEPTH));
    check("busy", 32'(bus.busy), 32'(m_active || mq.size() != 0));
    check("order_dropped", 32'(bus.order_dropped), 32'(m_dropped));
    check("drop_count", 32'(bus.drop_count), 32'(m_dc));
    if (bus.tx_valid && bus.tx_ready) cap.push_back('{d: bus.tx_data, l: bus.tx_last, c: cyc});
    if (bus.order_dropped) drop_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [4:0] id, logic [31:0] amt);
    bus.send_order = 1'b1;
    bus.order_client_id = id;
    bus.order_amount = amt;
    tick();
    bus.send_order = 1'b0;
  endtask

  task automatic wait_caps(int n, int limit);
    int k;
    k = 0;
    while (cap.size() < n && k < limit) begin tick(); k++; end
    checks++;
    if (cap.size() < n) begin
      errors++;
      $display("FAIL wait_caps: got %0d bytes, expected %0d", cap.size(), n);
    end
  endtask

  task automatic wait_idle(int limit);
    int k;
    k = 0;
    while (bus.busy && k < limit) begin tick(); k++; end
    check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic compare_frame(int base, int v);
    for (int i = 0; i < 7; i++) begin
      if (base + i < cap.size()) begin
        check($sformatf("vec%0d_byte%0d", v, i), 32'(cap[base + i].d), 32'(byte_of(vt[v].exp, i)));
        check($sformatf("vec%0d_last%0d", v, i), 32'(cap[base + i].l), 32'(i == 6));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dp0;
    vt[0] = '{id: 5'd3,  amt: 32'h0000_1234, exp: 56'hA5_03_00_00_12_34_25};
    vt[1] = '{id: 5'd1,  amt: 32'h0000_0001, exp: 56'hA5_01_00_00_00_01_00};
    vt[2] = '{id: 5'd2,  amt: 32'h0000_0002, exp: 56'hA5_02_00_00_00_02_00};
    vt[3] = '{id: 5'd3,  amt: 32'h0000_0003, exp: 56'hA5_03_00_00_00_03_00};
    vt[4] = '{id: 5'h1F, amt: 32'hFFFF_FFFF, exp: 56'hA5_1F_FF_FF_FF_FF_1F};
    vt[5] = '{id: 5'h10, amt: 32'hDEAD_BEEF, exp: 56'hA5_10_DE_AD_BE_EF_32};

    bus.send_order = 1'b0; bus.order_client_id = '0; bus.order_amount = '0; bus.tx_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_last", 32'(bus.tx_last), 32'd0);
    check("rst_fifo_full", 32'(bus.fifo_full), 32'd0);
    check("rst_order_dropped", 32'(bus.order_dropped), 32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Each vector as a standalone frame with the link always ready.
    bus.tx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      cap.delete();
      send(vt[v].id, vt[v].amt);
      wait_caps(7, 40);
      compare_frame(0, v);
      wait_idle(20);
    end

    // Latency: SOF appears two edges after the pulse is sampled.
    cap.delete();
    send(vt[0].id, vt[0].amt);
    check("lat_e0_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    check("lat_e1_valid", 32'(bus.tx_valid), 32'd1);
    check("lat_e1_sof", 32'(bus.tx_data), 32'hA5);
    wait_caps(7, 40);
    compare_frame(0, 0);
    wait_idle(20);

    // Backpressure on the amount MSB byte.
    cap.delete();
    send(vt[0].id, vt[0].amt);
    repeat (3) tick();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(bus.tx_valid), 32'd1);
      check("bp_data", 32'(bus.tx_data), 32'h00);
      check("bp_last", 32'(bus.tx_last), 32'd0);
    end
    bus.tx_ready = 1'b1;
    wait_caps(7, 40);
    compare_frame(0, 0);
    wait_idle(20);

    // Back-to-back frames with no idle cycle between them.
    cap.delete();
    for (int v = 1; v <= 3; v++) send(vt[v].id, vt[v].amt);
    wait_caps(21, 60);
    compare_frame(0, 1);
    compare_frame(7, 2);
    compare_frame(14, 3);
    if (cap.size() >= 21) check("b2b_span", 32'(cap[20].c - cap[0].c), 32'd20);
    wait_idle(20);

    // Overflow: one order in the frame register, four queued, sixth dropped.
    bus.tx_ready = 1'b0;
    cap.delete();
    dp0 = drop_pulses;
    for (int i = 0; i < 6; i++) send(5'(i + 1), 32'(100 + i));
    check("ovf_dropped", 32'(bus.order_dropped), 32'd1);
    check("ovf_full", 32'(bus.fifo_full), 32'd1);
    check("ovf_drop_count", 32'(bus.drop_count), 32'd1);
    tick();
    check("ovf_drop_pulses", 32'(drop_pulses - dp0), 32'd1);

    // Push at the same edge as a CHK pop while full is still dropped.
    bus.tx_ready = 1'b1;
    n = 0;
    while (!bus.tx_last && n < 20) begin tick(); n++; end
    check("pp_at_chk", 32'(bus.tx_last), 32'd1);
    send(5'd7, 32'd777);
    check("pp_dropped", 32'(bus.order_dropped), 32'd1);
    check("pp_drop_count", 32'(bus.drop_count), 32'd2);
    check("pp_not_full", 32'(bus.fifo_full), 32'd0);
    wait_caps(35, 100);
    for (int k = 0; k < 5; k++)
      if (7 * k + 1 < cap.size()) check("pp_id_order", 32'(cap[7 * k + 1].d), 32'(k + 1));
    wait_idle(20);
    check("pp_total_bytes", 32'(cap.size()), 32'd35);

    // Drop counter saturation.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) send(5'($urandom), $urandom);
    check("sat_drop_count", 32'(bus.drop_count), 32'd255);
    bus.tx_ready = 1'b1;
    wait_idle(100);

    // Reset mid-frame after three bytes, then a fresh frame.
    cap.delete();
    send(vt[0].id, vt[0].amt);
    repeat (4) tick();
    check("mid_bytes_sent", 32'(cap.size()), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_drop_count", 32'(bus.drop_count), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_last", 32'(bus.tx_last), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    cap.delete();
    send(vt[5].id, vt[5].amt);
    wait_caps(7, 40);
    compare_frame(0, 5);
    wait_idle(20);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bus.tx_ready = ($urandom_range(0, 9) < 7);
      bus.send_order = ($urandom_range(0, 3) == 0);
      bus.order_client_id = 5'($urandom);
      bus.order_amount = $urandom;
      tick();
    end
    bus.send_order = 1'b0;
    bus.tx_ready = 1'b1;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
